mux_pipe: RTL and testbench
===========================

MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits per channel.
REQ-002 SHALL have parameter N, default 4, number of input channels (legal 2..8).
REQ-003 SHALL have parameter MODE, default 0: 0 = select-driven, 1 = round-robin arbitration.
REQ-004 SHALL derive SELW = max(1, clog2(N)) internally; SELW is not user-set.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port in_data, input, N*WIDTH; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, N, per-channel valid.
REQ-009 SHALL have port in_ready, output, N, per-channel ready.
REQ-010 SHALL have port sel, input, SELW, channel select; used in MODE 0 only, ignored in MODE 1.
REQ-011 SHALL have port flush, input, 1, drops the held output entry.
REQ-012 SHALL have port out_data, output, WIDTH, registered output data.
REQ-013 SHALL have port out_valid, output, 1, output entry valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts.
REQ-015 SHALL have port out_src, output, SELW, index of the channel that supplied out_data.

Function
REQ-016 SHALL hold one output entry (out_data, out_src, out_valid); latency input-to-output is exactly 1 cycle.
REQ-017 SHALL define can_accept = !flush && (!out_valid || out_ready).
REQ-018 In MODE 0, SHALL set in_ready[i] = can_accept && (sel == i); when sel >= N, all in_ready SHALL be 0.
REQ-019 In MODE 1, SHALL grant the first channel with in_valid set, searching from (rr_ptr+1) mod N upward with wrap-around; in_ready[grant] = can_accept, all others 0; no valid channel means no grant.
REQ-020 SHALL count a transfer on channel g when in_valid[g] && in_ready[g]; the next cycle it SHALL load out_data = channel g data, out_src = g, out_valid = 1.
REQ-021 In MODE 1, SHALL set rr_ptr = g only on a transfer; rr_ptr SHALL be unchanged otherwise, including during flush.
REQ-022 SHALL hold out_data and out_src stable while out_valid && !out_ready && !flush.
REQ-023 When out_valid && out_ready and no transfer occurs, SHALL clear out_valid next cycle; out_data and out_src keep their last values.
REQ-024 When out_valid && out_ready and a transfer occurs in the same cycle, SHALL replace the entry with no bubble, sustaining 1 transfer per cycle.
REQ-025 When flush = 1, SHALL clear out_valid next cycle, accept no input that cycle, and ignore out_ready.
REQ-026 in_ready SHALL depend only on registered state, flush, sel, in_valid and out_ready; no combinational path from in_data to in_ready.
REQ-027 in_ready SHALL be at most one-hot in every cycle.

Reset
REQ-028 When reset = 1 at a clock edge, SHALL set out_valid = 0, out_data = 0, out_src = 0, rr_ptr = N-1 (so channel 0 has first priority); reset SHALL take precedence over flush and transfers.
REQ-029 During reset cycles, in_ready SHALL be all 0; an entry held mid-stall SHALL be discarded.

Verification (WIDTH=32, N=4)
REQ-030 MODE 0, sel=2, in_valid=4'b0100, ch2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_src=2; in_ready=4'b0100 on the transfer cycle.
REQ-031 MODE 0, entry 0x11 held, out_ready=0 for 3 cycles, ch1=0x22 valid, sel=1 -> out_data stays 0x11 and in_ready=0 for 3 cycles; out_ready=1 -> 0x22 appears next cycle, no bubble.
REQ-032 MODE 1, in_valid=4'b1111 held, out_ready=1 for 6 cycles after reset -> out_src sequence 0,1,2,3,0,1.
REQ-033 MODE 1, in_valid=4'b1010, rr_ptr=1 -> grant 3, then grant 1; when out_ready=0 for 2 cycles, grant and rr_ptr stay unchanged.
REQ-034 Entry valid, flush=1 with ch0 valid and sel=0 -> next cycle out_valid=0, no transfer counted; flush=0 -> ch0 accepted, appears the following cycle.
REQ-035 Entry valid with out_ready=0, reset=1 for 1 cycle -> out_valid=0, out_data=0, out_src=0; MODE 1 next grant from channel 0.

Source files
------------

// File: rtl/mux_pipe.sv
// mux_pipe: N-channel valid/ready multiplexer with a single registered
// output entry; select-driven (MODE 0) or round-robin (MODE 1).
module mux_pipe #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int MODE = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic             found;
  logic             can_accept;
  logic [N-1:0]     ready;
  logic             xfer;
  logic [WIDTH-1:0] pick;
  logic [SELW-1:0]  src;

  // Reset also blocks acceptance so nothing is taken during reset cycles
  assign can_accept = !reset && !flush && (!out_valid || out_ready);

  // Round-robin search starting just after the last granted channel
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && in_valid[(int'(rr_ptr) + k) % N]) begin
        found = 1'b1;
        grant = SELW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  // One-hot ready; never depends on in_data
  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      if (MODE == 0) begin
        ready[i] = can_accept && (int'(sel) == i);
      end else begin
        ready[i] = can_accept && found && (int'(grant) == i);
      end
    end
  end

  assign in_ready = ready;

  // Pick the data and index of the channel completing a handshake
  always_comb begin
    xfer = 1'b0;
    pick = '0;
    src  = '0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && ready[i]) begin
        xfer = 1'b1;
        pick = in_data[i*WIDTH +: WIDTH];
        src  = SELW'(i);
      end
    end
  end

  // Output entry: reset, then flush, then load, then drain
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= pick;
      out_src   <= src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Arbitration pointer moves only on an accepted transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= SELW'(N - 1);
    end else if (MODE == 1 && xfer) begin
      rr_ptr <= src;
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed vector table for select mode plus
// hand-written round-robin sequences on a second instance.
module tb_mux_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [1:0]   sel;
  logic         flush;
  logic         out_ready;

  logic [3:0]   ir0, ir1;
  logic [31:0]  od0, od1;
  logic         ov0, ov1;
  logic [1:0]   os0, os1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(32), .N(4), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_ready(ir0), .sel(sel),
    .flush(flush), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .out_src(os0)
  );

  mux_pipe #(.WIDTH(32), .N(4), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_ready(ir1), .sel(sel),
    .flush(flush), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .out_src(os1)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic [1:0]  s;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle on the round-robin instance and check it
  task automatic m1(input string nm, input logic r,
                    input logic [3:0] iv, input logic ordy,
                    input logic [3:0] eir, input logic eov,
                    input logic [31:0] eod, input logic [1:0] eos);
    reset = r;
    flush = 1'b0;
    in_valid = iv;
    out_ready = ordy;
    #1;
    chk({nm, ".in_ready"}, 32'(ir1), 32'(eir));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(ov1), 32'(eov));
    chk({nm, ".out_data"}, od1, eod);
    chk({nm, ".out_src"}, 32'(os1), 32'(eos));
  endtask

  initial begin
    in_data = {32'h44, 32'hDEADBEEF, 32'h22, 32'h11};
    reset = 1'b1;
    flush = 1'b0;
    sel = 2'd0;
    in_valid = 4'h0;
    out_ready = 1'b0;

    //          rst   fl    sel   iv    ordy  ir    ov    od            os
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,        2'd0};
    tbl[1]  = '{1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 4'h4, 1'b1, 32'hDEADBEEF, 2'd2};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h11,       2'd0};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 4'h2, 1'b0, 4'h0, 1'b1, 32'h11,       2'd0};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 4'h2, 1'b0, 4'h0, 1'b1, 32'h11,       2'd0};
    tbl[5]  = '{1'b0, 1'b0, 2'd1, 4'h2, 1'b0, 4'h0, 1'b1, 32'h11,       2'd0};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 4'h2, 1'b1, 4'h2, 1'b1, 32'h22,       2'd1};
    tbl[7]  = '{1'b0, 1'b0, 2'd1, 4'h0, 1'b1, 4'h2, 1'b0, 32'h22,       2'd1};
    tbl[8]  = '{1'b0, 1'b0, 2'd3, 4'h8, 1'b0, 4'h8, 1'b1, 32'h44,       2'd3};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'h1, 1'b0, 4'h0, 1'b0, 32'h44,       2'd3};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 4'h1, 1'b0, 4'h1, 1'b1, 32'h11,       2'd0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b1, 32'h11,       2'd0};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 4'h1, 1'b0, 4'h0, 1'b0, 32'h0,        2'd0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 4'h1, 1'b1, 4'h1, 1'b1, 32'h11,       2'd0};
    tbl[14] = '{1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 4'h0, 1'b0, 32'h11,       2'd0};

    @(posedge clk);
    #1;
    for (int v = 0; v < 15; v++) begin
      reset = tbl[v].rst;
      flush = tbl[v].fl;
      sel = tbl[v].s;
      in_valid = tbl[v].iv;
      out_ready = tbl[v].ordy;
      #1;
      chk($sformatf("m0v%0d.in_ready", v), 32'(ir0), 32'(tbl[v].ir));
      @(posedge clk);
      #1;
      chk($sformatf("m0v%0d.out_valid", v), 32'(ov0), 32'(tbl[v].ov));
      chk($sformatf("m0v%0d.out_data", v), od0, tbl[v].od);
      chk($sformatf("m0v%0d.out_src", v), 32'(os0), 32'(tbl[v].os));
    end
    sel = 2'd0;

    m1("rr_rst", 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0, 2'd0);
    m1("rr_c0", 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'h11, 2'd0);
    m1("rr_c1", 1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 32'h22, 2'd1);
    m1("rr_c2", 1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 32'hDEADBEEF, 2'd2);
    m1("rr_c3", 1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 32'h44, 2'd3);
    m1("rr_c4", 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'h11, 2'd0);
    m1("rr_c5", 1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 32'h22, 2'd1);

    m1("rr_sp3", 1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 32'h44, 2'd3);
    m1("rr_st0", 1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 32'h44, 2'd3);
    m1("rr_st1", 1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 32'h44, 2'd3);
    m1("rr_sp1", 1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 32'h22, 2'd1);

    m1("rr_mrst", 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0, 2'd0);
    m1("rr_after", 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'h11, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
